// File: rtl/mem_access_ctrl.sv
// Memory access sequencer for the MAR/MDR datapath.
// One read or write transaction runs per request. The sequence is: load MAR,
// strobe memory until mem_ready (bounded by TIMEOUT), capture the read data
// into MDR, then pulse done. Every output is a register that holds the Moore
// decode of the state, so no input reaches an output combinationally.
module mem_access_ctrl #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic clock,
  input  logic clear_n,
  input  logic start_read,
  input  logic start_write,
  input  logic mem_ready,
  output logic mar_in,
  output logic mem_read,
  output logic mem_write,
  output logic mdr_in,
  output logic mdr_read,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Last ACCESS cycle index. The counter is only compared against this value
  // and the state leaves ACCESS once it is reached, so the counter never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 op_rd_q, op_rd_d;
  logic                 err_q, err_d;

  logic mar_in_q, mem_read_q, mem_write_q, mdr_in_q, mdr_read_q;
  logic busy_q, done_q, timeout_err_q;
  logic mar_in_d, mem_read_d, mem_write_d, mdr_in_d, mdr_read_d;
  logic busy_d, done_d, timeout_err_d;

  // Next-state logic. Outputs are decoded from the next state so that the
  // registered outputs line up with the registered state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        // When both requests arrive together, the read takes priority.
        if (start_read) begin
          state_d = S_ADDR;
          op_rd_d = 1'b1;
          err_d   = 1'b0;
        end else if (start_write) begin
          state_d = S_ADDR;
          op_rd_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        // mem_ready takes priority over the timeout when both occur on the
        // last ACCESS cycle.
        if (mem_ready) begin
          state_d = op_rd_q ? S_CAPTURE : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    mar_in_d      = (state_d == S_ADDR);
    mem_read_d    = (state_d == S_ACCESS) &&  op_rd_d;
    mem_write_d   = (state_d == S_ACCESS) && !op_rd_d;
    mdr_in_d      = (state_d == S_CAPTURE);
    mdr_read_d    = (state_d == S_CAPTURE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    timeout_err_d = (state_d == S_DONE) && err_d;
  end

  // State, flags and registered outputs. Reset is asynchronous, so the
  // strobes drop as soon as clear_n falls.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_rd_q       <= 1'b0;
      err_q         <= 1'b0;
      mar_in_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mdr_in_q      <= 1'b0;
      mdr_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_rd_q       <= op_rd_d;
      err_q         <= err_d;
      mar_in_q      <= mar_in_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mdr_in_q      <= mdr_in_d;
      mdr_read_q    <= mdr_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mar_in      = mar_in_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mdr_in      = mdr_in_q;
  assign mdr_read    = mdr_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl.
// Each transaction in the table is expanded into a cycle-by-cycle trace of the
// expected outputs. The trace is pushed to a queue when the request is driven,
// and one entry is popped and compared on every following cycle.
// Output vector: {mar_in, mem_read, mem_write, mdr_in, mdr_read, busy, done, timeout_err}
module tb_mem_access_ctrl;

  localparam int TIMEOUT   = 16;
  localparam int CNT_WIDTH = 5;

  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_ADDR  = 8'b1000_0100;
  localparam logic [7:0] V_ACC_R = 8'b0100_0100;
  localparam logic [7:0] V_ACC_W = 8'b0010_0100;
  localparam logic [7:0] V_CAP   = 8'b0001_1100;
  localparam logic [7:0] V_DONE  = 8'b0000_0110;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  logic start_read = 1'b0;
  logic start_write = 1'b0;
  logic mem_ready = 1'b0;
  logic mar_in, mem_read, mem_write, mdr_in, mdr_read, busy, done, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic  rd;
    logic  wr;
    int    ready_at;   // ACCESS cycle (1-based) in which mem_ready is high; 0 = never
    logic  poke;       // pulse start_write while busy
    string name;
  } vec_t;

  vec_t vecs[10];

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start_read  (start_read),
    .start_write (start_write),
    .mem_ready   (mem_ready),
    .mar_in      (mar_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mdr_in      (mdr_in),
    .mdr_read    (mdr_read),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] outs();
    return {mar_in, mem_read, mem_write, mdr_in, mdr_read, busy, done, timeout_err};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Drive one request and compare the outputs of every cycle against the
  // trace built from the transaction's description.
  task automatic run_txn(input vec_t v);
    int         n_acc;
    int         c;
    logic       is_rd;
    logic       terr;
    logic [7:0] exp;
    is_rd = v.rd;
    terr  = (v.ready_at == 0);
    n_acc = terr ? TIMEOUT : v.ready_at;
    exp_q.push_back(V_ADDR);
    for (int k = 0; k < n_acc; k++) exp_q.push_back(is_rd ? V_ACC_R : V_ACC_W);
    if (is_rd && !terr) exp_q.push_back(V_CAP);
    exp_q.push_back(V_DONE | {7'b0, terr});
    exp_q.push_back(V_IDLE);
    start_read  = v.rd;
    start_write = v.wr;
    c = 0;
    while (exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      c++;
      start_read  = 1'b0;
      start_write = v.poke && (c == 2);
      mem_ready   = (v.ready_at != 0) && (c == 1 + v.ready_at);
      exp = exp_q.pop_front();
      check($sformatf("%s cyc%0d", v.name, c), outs(), exp);
    end
    start_write = 1'b0;
    mem_ready   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1,  1'b0, "read_ready1"};
    vecs[1] = '{1'b1, 1'b0, 3,  1'b0, "read_ready3"};
    vecs[2] = '{1'b0, 1'b1, 1,  1'b0, "write_ready1"};
    vecs[3] = '{1'b1, 1'b0, 0,  1'b0, "read_timeout"};
    vecs[4] = '{1'b1, 1'b0, 1,  1'b0, "read_after_timeout"};
    vecs[5] = '{1'b1, 1'b0, 16, 1'b0, "read_ready_last"};
    vecs[6] = '{1'b1, 1'b1, 2,  1'b0, "both_start_read_wins"};
    vecs[7] = '{1'b1, 1'b0, 2,  1'b1, "write_poke_while_busy"};
    vecs[8] = '{1'b0, 1'b1, 0,  1'b0, "write_timeout"};
    vecs[9] = '{1'b0, 1'b1, 16, 1'b0, "write_ready_last"};

    // Reset state
    #2;
    check("reset_outputs", outs(), V_IDLE);
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle_after_release", outs(), V_IDLE);

    // Asynchronous clear during the ACCESS state of a read
    start_read = 1'b1;
    @(posedge clock);
    #1;
    start_read = 1'b0;
    check("rst_seq addr", outs(), V_ADDR);
    @(posedge clock);
    #1;
    check("rst_seq access", outs(), V_ACC_R);
    #3;
    clear_n = 1'b0;
    #1;
    check("rst_seq async_clear", outs(), V_IDLE);
    @(posedge clock);
    #1;
    check("rst_seq held", outs(), V_IDLE);
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_seq idle", outs(), V_IDLE);
    run_txn('{1'b1, 1'b0, 1, 1'b0, "read_after_reset"});

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Requests are ignored while the controller is busy
    start_write = 1'b1;
    @(posedge clock);
    #1;
    start_write = 1'b0;
    check("ignored_ws addr", outs(), V_ADDR);
    start_read = 1'b1;
    @(posedge clock);
    #1;
    start_read = 1'b0;
    mem_ready  = 1'b1;
    check("ignored_ws access", outs(), V_ACC_W);
    @(posedge clock);
    #1;
    mem_ready = 1'b0;
    check("ignored_ws done", outs(), V_DONE);
    @(posedge clock);
    #1;
    check("ignored_ws idle", outs(), V_IDLE);
    @(posedge clock);
    #1;
    check("ignored_ws stays_idle", outs(), V_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
